// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer: state encoding, error codes and image header size.
package boot_sequencer_pkg;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_CSUM_HI = 4'd6;
    localparam logic [3:0] ST_CSUM_LO = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;
    localparam logic [3:0] ST_ERROR   = 4'd9;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_CSUM    = 2'b11;

    // LEN_HI + LEN_LO precede the data words.
    localparam int unsigned HDR_BYTES = 2;

    function automatic logic takes_byte(input logic [3:0] st);
        return st inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM_HI, ST_CSUM_LO};
    endfunction

endpackage

// File: rtl/boot_sequencer_byte_packer.sv
// Packs a big-endian HI/LO byte pair into a 16-bit word; word_valid strobes with the LO byte.
module boot_sequencer_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_byte,
    input  logic        hi_en,
    input  logic        lo_en,
    output logic [15:0] word,
    output logic        word_valid
);

    logic [7:0] hi_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
        end else if (hi_en) begin
            hi_q <= data_byte;
        end
    end

    assign word       = {hi_q, data_byte};
    assign word_valid = lo_en;

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams a length-prefixed image from storage into memory via the boot port.
// Optional trailing checksum check enabled by defining BOOT_CHECKSUM_EN.
module boot_sequencer
    import boot_sequencer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter logic [15:0] MAX_WORDS   = 16'hC000,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_storeByte,
    input  logic        i_storeValid,
    output logic        o_storeReady,
    output logic [15:0] o_bootMemAddr,
    output logic [15:0] o_bootDataOut,
    output logic        o_bootMemEn,
    output logic        o_isBooted,
    output logic        o_bootErr,
    output logic [1:0]  o_errCode
);

`ifdef BOOT_CHECKSUM_EN
    localparam logic [3:0] ST_FINAL = ST_CSUM_HI;
`else
    localparam logic [3:0] ST_FINAL = ST_DONE;
`endif
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    logic [3:0]  state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] tmo_q, tmo_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  code_q, code_d;
    logic        ready_q, en_q, booted_q, err_q;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
`endif

    logic        accept, hi_en, lo_en, word_valid;
    logic [15:0] word;

    assign accept = ready_q & i_storeValid;
    assign hi_en  = accept & (state_q inside {ST_LEN_HI, ST_DATA_HI, ST_CSUM_HI});
    assign lo_en  = accept & (state_q inside {ST_LEN_LO, ST_DATA_LO, ST_CSUM_LO});

    boot_sequencer_byte_packer u_packer (
        .clk        (i_clk),
        .rst        (i_rst),
        .data_byte  (i_storeByte),
        .hi_en      (hi_en),
        .lo_en      (lo_en),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmo_d   = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        code_d  = code_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LEN_HI;
                    idx_d   = '0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI:  if (accept) state_d = ST_LEN_LO;
            ST_LEN_LO: begin
                if (word_valid) begin
                    len_d = word;
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ word;
`endif
                    if (word > MAX_WORDS) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_LEN;
                    end else if (word == 16'd0) begin
                        state_d = ST_FINAL;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: if (accept) state_d = ST_DATA_LO;
            ST_DATA_LO: begin
                if (word_valid) begin
                    state_d = ST_WRITE;
                    addr_d  = BASE_ADDR + idx_q;
                    data_d  = word;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = csum_q ^ word;
`endif
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 16'd1;
                state_d = ((idx_q + 16'd1) == len_q) ? ST_FINAL : ST_DATA_HI;
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM_HI: if (accept) state_d = ST_CSUM_LO;
            ST_CSUM_LO: begin
                if (word_valid) begin
                    if (word == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                        code_d  = ERR_CSUM;
                    end
                end
            end
`endif
            ST_DONE, ST_ERROR: state_d = state_q;
            default: state_d = ST_IDLE;
        endcase

        // An arriving byte always beats the timeout, so only idle ready cycles count.
        if (ready_q && !i_storeValid) begin
            if (tmo_q == TMO_LAST) begin
                state_d = ST_ERROR;
                code_d  = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            code_q   <= ERR_NONE;
            ready_q  <= 1'b0;
            en_q     <= 1'b0;
            booted_q <= 1'b0;
            err_q    <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            code_q   <= code_d;
            ready_q  <= takes_byte(state_d);
            en_q     <= (state_d == ST_WRITE);
            booted_q <= (state_d == ST_DONE);
            err_q    <= (state_d == ST_ERROR);
`ifdef BOOT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign o_storeReady  = ready_q;
    assign o_bootMemAddr = addr_q;
    assign o_bootDataOut = data_q;
    assign o_bootMemEn   = en_q;
    assign o_isBooted    = booted_q;
    assign o_bootErr     = err_q;
    assign o_errCode     = code_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: table vectors, hand-written corner cases and
// randomized images compared against an image-level reference model.
module tb_boot_sequencer;
    import boot_sequencer_pkg::*;

    localparam int          TMO  = 40;
    localparam logic [15:0] MAXW = 16'hC000;
    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst, start, valid;
    logic [7:0]  sbyte;
    logic        ready, en, booted, berr;
    logic [15:0] addr, dout;
    logic [1:0]  code;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] got_addr[$];
    logic [15:0] got_data[$];
    int          en_double = 0;
    logic        en_prev = 1'b0;

    logic [15:0] img_len;
    logic [15:0] img_words[$];
    logic [15:0] img_csum;
    logic [15:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic        exp_booted, exp_err;
    logic [1:0]  exp_code;

    typedef struct {
        logic [15:0] len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] csum;
        logic        booted;
        logic        err;
        logic [1:0]  code;
        int          nwr;
    } vec_t;
    vec_t tbl[5];

    boot_sequencer #(
        .BASE_ADDR   (BASE),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_storeByte   (sbyte),
        .i_storeValid  (valid),
        .o_storeReady  (ready),
        .o_bootMemAddr (addr),
        .o_bootDataOut (dout),
        .o_bootMemEn   (en),
        .o_isBooted    (booted),
        .o_bootErr     (berr),
        .o_errCode     (code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (en) begin
            got_addr.push_back(addr);
            got_data.push_back(dout);
        end
        if (en && en_prev) en_double <= en_double + 1;
        en_prev <= en;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        got_addr.delete();
        got_data.delete();
        en_double = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; valid = 1'b0; sbyte = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_capture();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < gap; i++) tick();
        sbyte = b;
        valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        sbyte = 8'($urandom);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap_max, input bit noise,
                             inout bit all_ok);
        bit ok;
        logic [7:0] hi, lo;
        hi = w[15:8];
        lo = w[7:0];
        if (noise && $urandom_range(0, 2) == 0) start = 1'b1;
        send_byte(hi, int'($urandom_range(0, gap_max)), ok);
        all_ok &= ok;
        send_byte(lo, int'($urandom_range(0, gap_max)), ok);
        all_ok &= ok;
        start = 1'b0;
    endtask

    // Reference: what the memory should receive and how the boot ends, from the image alone.
    task automatic model();
        logic [15:0] x;
        exp_addr.delete();
        exp_data.delete();
        exp_code = 2'd0;
        if (img_len > MAXW) begin
            exp_booted = 1'b0; exp_err = 1'b1; exp_code = 2'd1;
            return;
        end
        x = img_len;
        for (int i = 0; i < int'(img_len); i++) begin
            exp_addr.push_back(BASE + 16'(i));
            exp_data.push_back(img_words[i]);
            x ^= img_words[i];
        end
`ifdef BOOT_CHECKSUM_EN
        if (x == img_csum) begin
            exp_booted = 1'b1; exp_err = 1'b0;
        end else begin
            exp_booted = 1'b0; exp_err = 1'b1; exp_code = 2'd3;
        end
`else
        exp_booted = 1'b1; exp_err = 1'b0;
`endif
    endtask

    task automatic run_image(input int gap_max, input bit noise, input bit do_rst);
        bit ok;
        bit all_ok;
        logic [7:0] hb;
        all_ok = 1'b1;
        if (do_rst) do_reset();
        pulse_start();
        for (int h = 0; h < int'(HDR_BYTES); h++) begin
            hb = (h == 0) ? img_len[15:8] : img_len[7:0];
            send_byte(hb, int'($urandom_range(0, gap_max)), ok);
            all_ok &= ok;
        end
        if (img_len <= MAXW) begin
            for (int i = 0; i < int'(img_len); i++) send_word(img_words[i], gap_max, noise, all_ok);
`ifdef BOOT_CHECKSUM_EN
            send_word(img_csum, gap_max, noise, all_ok);
`endif
        end
        check("byte_accept", 32'(all_ok), 32'd1);
        for (int w = 0; w < 50 && !(booted || berr); w++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic compare_vs_model(input string tag);
        model();
        check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
            check({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
        end
        check({tag, "_booted"}, 32'(booted), 32'(exp_booted));
        check({tag, "_err"}, 32'(berr), 32'(exp_err));
        check({tag, "_code"}, 32'(code), 32'(exp_code));
        check({tag, "_ready"}, 32'(ready), 32'd0);
        check({tag, "_en_1cyc"}, 32'(en_double), 32'd0);
    endtask

    task automatic post_start_check();
        int   n0;
        logic b0, e0;
        n0 = got_addr.size();
        b0 = booted;
        e0 = berr;
        tick();
        pulse_start();
        repeat (5) tick();
        @(negedge clk);
        check("post_start_nwr", 32'(got_addr.size()), 32'(n0));
        check("post_start_flags", {30'd0, booted, berr}, {30'd0, b0, e0});
        check("post_start_ready", 32'(ready), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        tbl[0] = '{16'h0002, 16'h1234, 16'hABCD, 16'hB9FB, 1'b1, 1'b0, 2'd0, 2};
        tbl[1] = '{16'hC001, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd1, 0};
        tbl[2] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'd0, 0};
        tbl[3] = '{16'h0001, 16'h00FF, 16'h0000, 16'h00FE, 1'b1, 1'b0, 2'd0, 1};
`ifdef BOOT_CHECKSUM_EN
        tbl[4] = '{16'h0001, 16'h00FF, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd3, 1};
`else
        tbl[4] = '{16'h0001, 16'h00FF, 16'h0000, 16'h0000, 1'b1, 1'b0, 2'd0, 1};
`endif

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_outputs", {25'd0, ready, en, booted, berr, code, 1'b0},
              32'd0);
        check("rst_addr_data", {addr, dout}, 32'd0);

        // Table vectors.
        for (int t = 0; t < 5; t++) begin
            img_len = tbl[t].len;
            img_words.delete();
            if (img_len >= 16'd1 && img_len <= MAXW) img_words.push_back(tbl[t].w0);
            if (img_len >= 16'd2 && img_len <= MAXW) img_words.push_back(tbl[t].w1);
            img_csum = tbl[t].csum;
            run_image(3, 1'b0, 1'b1);
            check("tbl_nwr", 32'(got_addr.size()), 32'(tbl[t].nwr));
            if (tbl[t].nwr >= 1 && got_addr.size() >= 1) begin
                check("tbl_w0", {got_addr[0], got_data[0]}, {BASE, tbl[t].w0});
            end
            if (tbl[t].nwr >= 2 && got_addr.size() >= 2) begin
                check("tbl_w1", {got_addr[1], got_data[1]}, {BASE + 16'd1, tbl[t].w1});
            end
            check("tbl_flags", {30'd0, booted, berr}, {30'd0, tbl[t].booted, tbl[t].err});
            check("tbl_code", 32'(code), 32'(tbl[t].code));
            check("tbl_ready", 32'(ready), 32'd0);
            check("tbl_en_1cyc", 32'(en_double), 32'd0);
        end

        // Byte arriving on the last idle cycle before timeout is taken.
        img_len = 16'd1;
        img_words.delete();
        img_words.push_back(16'h5A5A);
        img_csum = 16'h5A5B;
        do_reset();
        pulse_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        send_byte(8'h5A, TMO - 1, ok);
        check("tmo_edge_accept", 32'(ok), 32'd1);
        send_byte(8'h5A, 0, ok);
`ifdef BOOT_CHECKSUM_EN
        send_byte(8'h5A, 0, ok);
        send_byte(8'h5B, 0, ok);
`endif
        for (int w = 0; w < 20 && !(booted || berr); w++) @(negedge clk);
        compare_vs_model("tmo_edge");

        // Full timeout window with no byte.
        do_reset();
        pulse_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h01, 0, ok);
        repeat (TMO - 1) tick();
        @(negedge clk);
        check("tmo_before", {30'd0, berr, ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("tmo_err", {28'd0, berr, ready, code}, {28'd0, 1'b1, 1'b0, 2'd2});
        check("tmo_booted", 32'(booted), 32'd0);

        // Largest legal length is accepted.
        do_reset();
        pulse_start();
        send_byte(8'hC0, 0, ok);
        send_byte(8'h00, 0, ok);
        @(negedge clk);
        check("maxlen_ok", {30'd0, berr, ready}, 32'd1);

        // Reset during DATA_LO of word 3, then reboot without another reset.
        do_reset();
        pulse_start();
        send_byte(8'h00, 0, ok);
        send_byte(8'h05, 0, ok);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h11 * 8'(i + 1), 1, ok);
            send_byte(8'h22 * 8'(i + 1), 1, ok);
        end
        send_byte(8'h77, 0, ok);
        #2 rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {25'd0, ready, en, booted, berr, code, 1'b0}, 32'd0);
        check("midrst_addr_data", {addr, dout}, 32'd0);
        check("midrst_partial", 32'(got_addr.size()), 32'd3);
        tick();
        rst = 1'b0;
        tick();
        clear_capture();
        img_len = 16'd2;
        img_words.delete();
        img_words.push_back(16'hBEEF);
        img_words.push_back(16'hCAFE);
        img_csum = 16'h2 ^ 16'hBEEF ^ 16'hCAFE;
        run_image(2, 1'b0, 1'b0);
        compare_vs_model("reboot");

        // Randomized images with gaps and stray start pulses.
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 7) == 0) img_len = 16'hC001 + 16'($urandom_range(0, 16'h3FFE));
            else img_len = 16'($urandom_range(0, 6));
            img_words.delete();
            img_csum = img_len;
            if (img_len <= MAXW) begin
                for (int i = 0; i < int'(img_len); i++) begin
                    img_words.push_back(16'($urandom));
                    img_csum ^= img_words[i];
                end
            end
            if ($urandom_range(0, 2) == 0) img_csum ^= 16'(1 << $urandom_range(0, 15));
            run_image(4, 1'b1, 1'b1);
            compare_vs_model("rand");
            post_start_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
